// File: rtl/next_pc_unit_pkg.sv
// ============================================================================
// next_pc_unit_pkg : branch opcode encodings, FSM states and reset/exception
//                    vector defaults shared by the next-PC unit.
// Rev 1.0
// ============================================================================
`default_nettype none

package next_pc_unit_pkg;

   localparam int          ADDR_W_DEF    = 32;
   localparam logic [31:0] RESET_VEC_DEF = 32'hBFC0_0000;
   localparam logic [31:0] EXC_VEC_DEF   = 32'hBFC0_0380;

   typedef enum logic [3:0] {
      BR_BEQ    = 4'd0,
      BR_BNE    = 4'd1,
      BR_BGEZ   = 4'd2,
      BR_BGTZ   = 4'd3,
      BR_BLEZ   = 4'd4,
      BR_BLTZ   = 4'd5,
      BR_BGEZAL = 4'd6,
      BR_BLTZAL = 4'd7,
      BR_J      = 4'd8,
      BR_JAL    = 4'd9,
      BR_JR     = 4'd10,
      BR_JALR   = 4'd11
   } br_op_t;

   typedef enum logic [0:0] {
      ST_FETCH = 1'b0,
      ST_PEND  = 1'b1
   } pc_state_t;

   // Word-aligned branch displacement: sign-extend the 16-bit offset, shift by 2.
   function automatic logic [31:0] branch_disp(input logic [15:0] offset);
      return {{14{offset[15]}}, offset, 2'b00};
   endfunction

endpackage

`default_nettype wire

// File: rtl/next_pc_unit_if.sv
// ============================================================================
// next_pc_unit_if : instruction fetch request/accept handshake.
// Rev 1.0
// ============================================================================
`default_nettype none

interface next_pc_unit_if #(
   parameter int ADDR_W = 32
);
   logic              inst_req;
   logic [ADDR_W-1:0] inst_addr;
   logic              inst_addr_ok;

   modport master (output inst_req, output inst_addr, input  inst_addr_ok);
   modport slave  (input  inst_req, input  inst_addr, output inst_addr_ok);
endinterface

`default_nettype wire

// File: rtl/next_pc_unit_branch_cond.sv
// ============================================================================
// branch_cond : combinational taken/not-taken evaluation for MIPS branches.
// Rev 1.0
// ============================================================================
`default_nettype none

module branch_cond
   import next_pc_unit_pkg::*;
(
   input  wire logic        br_valid,
   input  wire logic [3:0]  br_op,
   input  wire logic [31:0] rs_val,
   input  wire logic [31:0] rt_val,
   output logic             taken
);

   br_op_t op;
   logic   cond;

   assign op = br_op_t'(br_op);

   always_comb begin
      cond = 1'b0;
      case (op)
         BR_BEQ:                cond = (rs_val == rt_val);
         BR_BNE:                cond = (rs_val != rt_val);
         BR_BGEZ, BR_BGEZAL:    cond = ~rs_val[31];
         BR_BGTZ:               cond = ~rs_val[31] & (|rs_val);
         BR_BLEZ:               cond = rs_val[31] | ~(|rs_val);
         BR_BLTZ, BR_BLTZAL:    cond = rs_val[31];
         BR_J, BR_JAL,
         BR_JR, BR_JALR:        cond = 1'b1;
         default:               cond = 1'b0;
      endcase
   end

   assign taken = br_valid & cond;

endmodule

`default_nettype wire

// File: rtl/next_pc_unit.sv
// ============================================================================
// next_pc_unit : MIPS fetch-address sequencer with branch redirect, exception
//                and eret entry. Macro BRANCH_DELAY_SLOT_EN keeps delay slots.
// Rev 1.0
// ============================================================================
`default_nettype none

module next_pc_unit
   import next_pc_unit_pkg::*;
#(
   parameter int                ADDR_W    = ADDR_W_DEF,
   parameter logic [ADDR_W-1:0] RESET_VEC = RESET_VEC_DEF,
   parameter logic [ADDR_W-1:0] EXC_VEC   = EXC_VEC_DEF
) (
   input  wire logic              clk,
   input  wire logic              resetn,
   input  wire logic              stall,
   input  wire logic              br_valid,
   input  wire logic [3:0]        br_op,
   input  wire logic [ADDR_W-1:0] br_pc,
   input  wire logic [15:0]       br_offset,
   input  wire logic [25:0]       j_index,
   input  wire logic [31:0]       rs_val,
   input  wire logic [31:0]       rt_val,
   input  wire logic              exc_req,
   input  wire logic              eret_req,
   input  wire logic [ADDR_W-1:0] epc,
   next_pc_unit_if.master         fetch,
   output logic                   br_taken,
   output logic [ADDR_W-1:0]      link_addr,
   output logic                   flush_if
);

`ifdef BRANCH_DELAY_SLOT_EN
   localparam logic FLUSH_ON_BRANCH = 1'b0;
`else
   localparam logic FLUSH_ON_BRANCH = 1'b1;
`endif

   pc_state_t         state;
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] redirect_q;
   logic              req_q;
   logic              flush_q;

   logic [ADDR_W-1:0] pc4;
   logic [ADDR_W-1:0] target;
   logic              advance;
   br_op_t            op;

   branch_cond u_branch_cond (
      .br_valid (br_valid),
      .br_op    (br_op),
      .rs_val   (rs_val),
      .rt_val   (rt_val),
      .taken    (br_taken)
   );

   assign op        = br_op_t'(br_op);
   assign pc4       = br_pc + ADDR_W'(4);
   assign link_addr = br_pc + ADDR_W'(8);
   assign advance   = req_q & fetch.inst_addr_ok & ~stall;

   always_comb begin
      target = pc4 + branch_disp(br_offset);
      case (op)
         BR_J, BR_JAL:   target = {pc4[ADDR_W-1:ADDR_W-4], j_index, 2'b00};
         BR_JR, BR_JALR: target = rs_val;
         default:        target = pc4 + branch_disp(br_offset);
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= ST_FETCH;
         pc_q       <= RESET_VEC;
         redirect_q <= '0;
         req_q      <= 1'b0;
         flush_q    <= 1'b0;
      end else begin
         req_q <= 1'b1;
         // Exception/eret override the handshake: the fetch in flight is abandoned.
         if (exc_req) begin
            state      <= ST_FETCH;
            pc_q       <= EXC_VEC;
            redirect_q <= '0;
            flush_q    <= 1'b1;
         end else if (eret_req) begin
            state      <= ST_FETCH;
            pc_q       <= epc;
            redirect_q <= '0;
            flush_q    <= 1'b1;
         end else begin
            flush_q <= br_taken & FLUSH_ON_BRANCH;
            if (advance) begin
               state <= ST_FETCH;
               if (br_taken)
                  pc_q <= target;
               else if (state == ST_PEND)
                  pc_q <= redirect_q;
               else
                  pc_q <= pc_q + ADDR_W'(4);
            end else if (br_taken) begin
               state      <= ST_PEND;
               redirect_q <= target;
            end
         end
      end
   end

   assign fetch.inst_req  = req_q;
   assign fetch.inst_addr = pc_q;
   assign flush_if        = flush_q;

endmodule

`default_nettype wire

// File: doc/next_pc_unit.md
NEXT_PC_UNIT -- requirements
Module: next_pc_unit

Interface
REQ-001 Parameter: ADDR_W, 32, fetch address width (fixed 32 for MIPS; any other value is a configuration error).
REQ-002 Parameter: RESET_VEC, 32'hBFC0_0000, first fetch address after reset.
REQ-003 Parameter: EXC_VEC, 32'hBFC0_0380, exception entry address.
REQ-004 Port: clk  in  1  sole clock; all state updates on rising edge.
REQ-005 Port: resetn  in  1  asynchronous, active-low reset.
REQ-006 Port: stall  in  1  downstream hold; PC shall not advance while high.
REQ-007 Port: br_valid  in  1  decode carries a branch/jump this cycle.
REQ-008 Port: br_op  in  4  branch/jump kind (BEQ, BNE, BGEZ, BGTZ, BLEZ, BLTZ, BGEZAL, BLTZAL, J, JAL, JR, JALR).
REQ-009 Port: br_pc  in  ADDR_W  address of the branch instruction.
REQ-010 Port: br_offset  in  16; j_index  in  26; rs_val, rt_val  in  32 each.
REQ-011 Port: exc_req  in  1; eret_req  in  1; epc  in  ADDR_W  (return address for eret).
REQ-012 Port: inst_req  out  1; inst_addr  out  ADDR_W; inst_addr_ok  in  1  (fetch request/accept).
REQ-013 Port: br_taken  out  1; link_addr  out  ADDR_W (= br_pc+8); flush_if  out  1.

Function
REQ-014 Targets: branch = br_pc+4+(sext(br_offset)<<2); J/JAL = {(br_pc+4)[31:28], j_index, 2'b00}; JR/JALR = rs_val; all sums wrap modulo 2^32.
REQ-015 Conditions: BEQ rs==rt; BNE rs!=rt; BGEZ/BGEZAL rs>=0 signed; BGTZ rs>0; BLEZ rs<=0; BLTZ/BLTZAL rs<0; jumps always taken; br_taken is combinational, 0 when br_valid=0.
REQ-016 Advance = inst_req & inst_addr_ok & ~stall; on advance inst_addr becomes the selected next address, otherwise holds.
REQ-017 Next-address priority: exc_req (EXC_VEC) > eret_req (epc) > br_taken (target) > pending redirect > inst_addr+4.
REQ-018 exc_req/eret_req shall load inst_addr on the next edge regardless of stall or inst_addr_ok and clear any pending redirect.
REQ-019 States: FETCH (request issued, waiting accept), PEND (taken target latched, not yet issued).
REQ-020 FETCH->PEND when br_taken and no advance; target captured in redirect register.
REQ-021 PEND->FETCH on next advance; inst_addr loads the redirect target, pending clears; a new br_taken while in PEND overwrites the latched target.
REQ-022 inst_req held high in both states after reset; inst_addr shall not change while inst_req=1 and inst_addr_ok=0, except for REQ-018.
REQ-023 Simultaneous exc_req and br_taken: exception wins, branch discarded.

Reset
REQ-024 While resetn=0: inst_req=0, inst_addr=RESET_VEC, state FETCH, pending=0, flush_if=0.
REQ-025 First edge after resetn rises: inst_req=1 with inst_addr=RESET_VEC; mid-operation reset discards pending redirect.

Configuration
REQ-026 Macro BRANCH_DELAY_SLOT_EN defined: instruction fetched after a branch (delay slot) executes, flush_if stays 0.
REQ-027 Macro absent: flush_if pulses 1 for one cycle on each taken branch, squashing the in-flight fetch at br_pc+4; exc/eret also assert flush_if in both builds.

Structure
REQ-028 Shared package holds br_op encodings and RESET_VEC/EXC_VEC defaults.
REQ-029 One sub-module, branch_cond, evaluates REQ-015 combinationally; rest is in next_pc_unit.

Verification
REQ-030 Reset release, inst_addr_ok=1 -> addresses 0xBFC00000, 0xBFC00004, 0xBFC00008 on consecutive cycles.
REQ-031 BEQ br_pc=0xBFC00010, off=0x0004, rs=rt=5 -> next inst_addr 0xBFC00024; rs=5, rt=6 -> 0xBFC00018 sequential.
REQ-032 BLTZ rs=0x80000000, inst_addr_ok=0 for 3 cycles -> PEND held, target issued on first accept cycle.
REQ-033 exc_req with stall=1 and br_taken=1 -> inst_addr=0xBFC00380 next edge, pending cleared, flush_if=1.
REQ-034 JALR rs=0x80001000, br_pc=0x80000100 -> target 0x80001000, link_addr 0x80000108; without BRANCH_DELAY_SLOT_EN flush_if=1 one cycle.
REQ-035 resetn low during PEND -> inst_req=0 immediately; after release fetch restarts at 0xBFC00000, no stale target.
